// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the combinational-cell BIST block.
package cell_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // x^16 + x^12 + x^3 + x + 1, with the x^16 term implicit in the shift-out
  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/cell_bist_if.sv
// Bundle of signals between the BIST engine and the cell under test / test controller.
interface cell_bist_if #(
  parameter int N = 6
);

  logic         start;
  logic [N-1:0] vec_out;
  logic         z_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;
  logic [15:0]  sig;

  modport master (
    output start, z_in,
    input  vec_out, busy, done, pass, err_count, first_fail, sig
  );

  modport slave (
    input  start, z_in,
    output vec_out, busy, done, pass, err_count, first_fail, sig
  );

endinterface

// File: rtl/cell_bist_misr.sv
// 16-bit multiple-input signature register compacting one response bit per enable.
module cell_bist_misr
  import cell_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_i,
  input  logic        en_i,
  input  logic        data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        fb;

  // Seeding takes priority so a new sweep always starts from a known signature
  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[15] ^ data_i;
    if (seed_i) begin
      sig_d = MISR_SEED;
    end else if (en_i) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/asic_cell_bist.sv
// Exhaustive-sweep BIST driver/checker for a small combinational cell.
// Define CELL_BIST_MISR_EN to add a 16-bit response signature on bus.sig.
module asic_cell_bist
  import cell_bist_pkg::*;
#(
  parameter int                 N      = 6,
  parameter logic [(1<<N)-1:0]  TRUTH  = 64'hFF80_8080_8080_8080,
  parameter int                 SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  cell_bist_if.slave  bus
);

  localparam int             CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);

  state_e         state_q;
  logic [N:0]     vec_q;
  logic [N:0]     vec_inc;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [N:0]     err_q;
  logic [N-1:0]   ff_q;
  logic           mismatch;

  // The extra counter bit flags the last vector without a wide compare
  assign vec_inc  = vec_q + (N+1)'(1);
  assign mismatch = bus.z_in != TRUTH[vec_q[N-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= HOLD;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + (N+1)'(1);
            if (err_q == '0) begin
              ff_q <= vec_q[N-1:0];
            end
          end
          if (vec_inc[N]) begin
            state_q <= DONE;
          end else begin
            vec_q   <= vec_inc;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vec_out    = vec_q[N-1:0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

`ifdef CELL_BIST_MISR_EN
  logic misr_seed;
  logic misr_en;

  assign misr_seed = (state_q == IDLE) && bus.start;
  assign misr_en   = (state_q == SAMPLE);

  cell_bist_misr u_misr (
    .clk    (clk),
    .reset  (reset),
    .seed_i (misr_seed),
    .en_i   (misr_en),
    .data_i (bus.z_in),
    .sig_o  (bus.sig)
  );
`else
  assign bus.sig = 16'h0000;
`endif

endmodule

// File: tb/tb_asic_cell_bist.sv
// Directed self-checking bench for asic_cell_bist driving a behavioural cell model.
module tb_asic_cell_bist;

  localparam int          N       = 6;
  localparam int          SETTLE  = 2;
  localparam logic [63:0] TRUTH_V = 64'hFF80_8080_8080_8080;
  localparam int          LAT     = 193;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  logic golden;
  int   checks   = 0;
  int   failures = 0;

  cell_bist_if #(.N(N)) bus ();

  asic_cell_bist #(
    .N      (N),
    .TRUTH  (TRUTH_V),
    .SETTLE (SETTLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Cell model: 0 = golden, 1 = output stuck-at-0, 2 = inverted on vector 6'h2A only
  assign golden   = TRUTH_V[bus.vec_out];
  assign bus.z_in = (mode == 1) ? 1'b0 :
                    ((mode == 2) && (bus.vec_out == 6'h2A)) ? ~golden : golden;

  task automatic runSweep(output int lat, output logic busyAfterStart);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    busyAfterStart = bus.busy;
    lat            = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    mode      = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.vec_out !== 6'd0) begin failures++; $display("[TB] FAIL reset_vec_out got=%0d exp=0", bus.vec_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass got=%b exp=0", bus.pass); end
    checks++; if (bus.err_count !== 7'd0) begin failures++; $display("[TB] FAIL reset_err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.first_fail !== 6'd0) begin failures++; $display("[TB] FAIL reset_first_fail got=%0d exp=0", bus.first_fail); end
`ifdef CELL_BIST_MISR_EN
    checks++; if (bus.sig !== 16'hFFFF) begin failures++; $display("[TB] FAIL reset_sig got=%h exp=ffff", bus.sig); end
`else
    checks++; if (bus.sig !== 16'h0000) begin failures++; $display("[TB] FAIL reset_sig got=%h exp=0000", bus.sig); end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_golden;
    int   lat;
    logic b0;
    mode = 0;
    runSweep(lat, b0);
    checks++; if (b0 !== 1'b1) begin failures++; $display("[TB] FAIL golden_busy_after_start got=%b exp=1", b0); end
    checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL golden_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("[TB] FAIL golden_pass got=%b exp=1", bus.pass); end
    checks++; if (bus.err_count !== 7'd0) begin failures++; $display("[TB] FAIL golden_err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.first_fail !== 6'd0) begin failures++; $display("[TB] FAIL golden_first_fail got=%0d exp=0", bus.first_fail); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL golden_busy_at_done got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL golden_done_width got=%b exp=0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.vec_out !== 6'd63) begin failures++; $display("[TB] FAIL golden_vec_hold got=%0d exp=63", bus.vec_out); end
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("[TB] FAIL golden_pass_hold got=%b exp=1", bus.pass); end
  endtask

  // TRUTH_V has 15 ones: 8 in the top byte plus bit 7 of the seven lower bytes
  task automatic test_stuck0;
    int   lat;
    logic b0;
    mode = 1;
    runSweep(lat, b0);
    checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL sa0_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.err_count !== 7'd15) begin failures++; $display("[TB] FAIL sa0_err_count got=%0d exp=15", bus.err_count); end
    checks++; if (bus.first_fail !== 6'd7) begin failures++; $display("[TB] FAIL sa0_first_fail got=%0d exp=7", bus.first_fail); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("[TB] FAIL sa0_pass got=%b exp=0", bus.pass); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.err_count !== 7'd15) begin failures++; $display("[TB] FAIL sa0_err_hold got=%0d exp=15", bus.err_count); end
  endtask

  task automatic test_single_fault;
    int   lat;
    logic b0;
    mode = 2;
    runSweep(lat, b0);
    checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL flip_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.err_count !== 7'd1) begin failures++; $display("[TB] FAIL flip_err_count got=%0d exp=1", bus.err_count); end
    checks++; if (bus.first_fail !== 6'h2A) begin failures++; $display("[TB] FAIL flip_first_fail got=%0d exp=42", bus.first_fail); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("[TB] FAIL flip_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_reset_abort;
    int   lat;
    logic b0;
    logic sawDone;
    mode    = 1;
    sawDone = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) sawDone = 1'b1;
    end
    checks++; if (bus.err_count !== 7'd2) begin failures++; $display("[TB] FAIL abort_err_before got=%0d exp=2", bus.err_count); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.vec_out !== 6'd0) begin failures++; $display("[TB] FAIL abort_vec_out got=%0d exp=0", bus.vec_out); end
    checks++; if (bus.err_count !== 7'd0) begin failures++; $display("[TB] FAIL abort_err_count got=%0d exp=0", bus.err_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done got=%b exp=0", sawDone); end
    mode = 0;
    runSweep(lat, b0);
    checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL abort_rerun_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("[TB] FAIL abort_rerun_pass got=%b exp=1", bus.pass); end
  endtask

  task automatic test_start_while_busy;
    int lat;
    mode = 0;
    lat  = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (c == 19) bus.start = 1'b1;
      if (c == 20) bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL busy_start_latency got=%0d exp=%0d", lat, LAT); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_no_requeue got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int first;
    int second;
    mode   = 0;
    first  = -1;
    second = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c <= 600; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (first < 0) first = c;
        else begin
          second = c;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (first != LAT) begin failures++; $display("[TB] FAIL b2b_first_done got=%0d exp=%0d", first, LAT); end
    checks++; if (second - first != LAT + 1) begin failures++; $display("[TB] FAIL b2b_period got=%0d exp=%0d", second - first, LAT + 1); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stop_busy got=%b exp=0", bus.busy); end
  endtask

`ifdef CELL_BIST_MISR_EN
  task automatic test_misr;
    int          lat;
    logic        b0;
    logic [15:0] sigA;
    logic [15:0] sigB;
    mode = 0;
    runSweep(lat, b0);
    sigA = bus.sig;
    runSweep(lat, b0);
    sigB = bus.sig;
    checks++; if (sigB !== sigA) begin failures++; $display("[TB] FAIL misr_repeat got=%h exp=%h", sigB, sigA); end
    checks++; if (sigA === 16'hFFFF) begin failures++; $display("[TB] FAIL misr_not_seed got=%h exp=not ffff", sigA); end
    mode = 2;
    runSweep(lat, b0);
    checks++; if (bus.sig === sigA) begin failures++; $display("[TB] FAIL misr_fault got=%h exp=not %h", bus.sig, sigA); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    mode      = 0;
    test_reset();
    test_golden();
    test_stuck0();
    test_single_fault();
    test_reset_abort();
    test_start_while_busy();
    test_back_to_back();
`ifdef CELL_BIST_MISR_EN
    test_misr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
